// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: draws LFSR candidate cells, scans the snake body
// memory for collisions and publishes the first free cell as the food position.
module food_spawn_ctrl #(
    parameter int          MAX_LEN   = 64,
    parameter int          IDX_W     = 6,
    parameter int          GRID_H    = 24,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       game_state,
    input  logic             get_food,
    input  logic [IDX_W:0]   snake_len,
    output logic [IDX_W-1:0] seg_addr,
    input  logic [4:0]       seg_x,
    input  logic [4:0]       seg_y,
    output logic [4:0]       food_x,
    output logic [4:0]       food_y,
    output logic             food_valid,
    output logic             busy,
    output logic             spawn_fail
);

    localparam int               LW        = IDX_W + 1;
    localparam int               CNT_W     = $clog2(MAX_TRIES + 1);
    localparam logic [15:0]      SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [LW-1:0]    MAX_LEN_W = LW'(MAX_LEN);
    localparam logic [5:0]       GRID_H_W  = 6'(GRID_H);
    localparam logic [CNT_W-1:0] TRIES_W   = CNT_W'(MAX_TRIES);
    localparam logic [1:0]       GS_PLAY   = 2'b00;
    localparam logic [1:0]       GS_PAUSE  = 2'b01;
    localparam logic [1:0]       GS_START  = 2'b10;
    localparam logic [1:0]       GS_OVER   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_SCAN,
        S_PUBLISH,
        S_FAIL
    } state_t;

    state_t           state_q;
    logic [15:0]      lfsr_q;
    logic [1:0]       gs_q;
    logic [4:0]       cand_x_q;
    logic [4:0]       cand_y_q;
    logic [LW-1:0]    len_q;
    logic [IDX_W-1:0] seg_addr_q;
    logic [IDX_W-1:0] cmp_idx_q;
    logic             pend_q;
    logic             reiss_q;
    logic [CNT_W-1:0] tries_q;
    logic [4:0]       food_x_q;
    logic [4:0]       food_y_q;
    logic             food_valid_q;
    logic             busy_q;
    logic             spawn_fail_q;

    logic [15:0]      lfsr_d;
    logic [LW-1:0]    len_eff;
    logic             start_edge;
    logic             food_req;
    logic             cy_oob;
    logic             hit;
    logic             scan_last;
    logic             addr_last;

    // x^16+x^15+x^13+x^4+1, shifting left with feedback into bit 0
    assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
    assign len_eff    = (snake_len > MAX_LEN_W) ? MAX_LEN_W : snake_len;
    assign start_edge = (game_state == GS_START) && (gs_q != GS_START);
    assign food_req   = get_food && (game_state == GS_PLAY) && (state_q == S_IDLE);
    assign cy_oob     = {1'b0, lfsr_q[12:8]} >= GRID_H_W;
    assign hit        = (seg_x == cand_x_q) && (seg_y == cand_y_q);
    assign scan_last  = ({1'b0, cmp_idx_q} + LW'(1)) == len_q;
    assign addr_last  = ({1'b0, seg_addr_q} + LW'(1)) >= len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED_EFF;
            gs_q         <= GS_PLAY;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            len_q        <= '0;
            seg_addr_q   <= '0;
            cmp_idx_q    <= '0;
            pend_q       <= 1'b0;
            reiss_q      <= 1'b0;
            tries_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            spawn_fail_q <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            gs_q   <= game_state;
            if (start_edge || food_req) begin
                state_q      <= S_DRAW;
                busy_q       <= 1'b1;
                food_valid_q <= 1'b0;
                spawn_fail_q <= 1'b0;
                tries_q      <= '0;
                pend_q       <= 1'b0;
                reiss_q      <= 1'b0;
            end else if (busy_q && (game_state == GS_OVER)) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                food_valid_q <= 1'b0;
                pend_q       <= 1'b0;
                reiss_q      <= 1'b0;
            end else if (game_state == GS_PAUSE) begin
                // The in-flight read is lost while paused; remember to re-issue it.
                if ((state_q == S_SCAN) && pend_q) begin
                    pend_q  <= 1'b0;
                    reiss_q <= 1'b1;
                end
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                    end
                    S_DRAW: begin
                        if (!cy_oob) begin
                            cand_x_q   <= lfsr_q[4:0];
                            cand_y_q   <= lfsr_q[12:8];
                            len_q      <= len_eff;
                            seg_addr_q <= '0;
                            pend_q     <= 1'b0;
                            state_q    <= (len_eff == '0) ? S_PUBLISH : S_SCAN;
                        end
                    end
                    S_SCAN: begin
                        if (reiss_q) begin
                            seg_addr_q <= cmp_idx_q;
                            reiss_q    <= 1'b0;
                        end else if (pend_q && hit) begin
                            tries_q <= tries_q + CNT_W'(1);
                            pend_q  <= 1'b0;
                            if ((tries_q + CNT_W'(1)) == TRIES_W) begin
                                state_q <= S_FAIL;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= S_DRAW;
                            end
                        end else if (pend_q && scan_last) begin
                            pend_q  <= 1'b0;
                            state_q <= S_PUBLISH;
                        end else begin
                            // Data for seg_addr_q arrives next cycle; hold the last address.
                            pend_q    <= 1'b1;
                            cmp_idx_q <= seg_addr_q;
                            if (!addr_last) begin
                                seg_addr_q <= seg_addr_q + IDX_W'(1);
                            end
                        end
                    end
                    S_PUBLISH: begin
                        food_x_q     <= cand_x_q;
                        food_y_q     <= cand_y_q;
                        food_valid_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                    S_FAIL: begin
                        spawn_fail_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seg_addr   = seg_addr_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = busy_q;
    assign spawn_fail = spawn_fail_q;

endmodule
